// File: rtl/onchip_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_sram_port_arbiter
//
// Shares one port of the 16K x 32 on-chip SRAM between two Avalon-MM
// requesters. Arbitration is round-robin with a bounded grant hold. A master
// can keep the port for up to MAX_HOLD consecutive transfers while the other
// master is waiting, so short bursts stream without starving the other side.
//
// Parameters
//   MAX_HOLD          consecutive grants one master may take while the other
//                     waits (1..15, 1 = pure round-robin)
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   m0_* / m1_*       Avalon-MM slave side for each master:
//                     address(14) byteenable(4) read write writedata(32)
//                     waitrequest readdata(32) readdatavalid
//   sram_*            SRAM port: chipselect write address(14) byteenable(4)
//                     writedata(32), readdata(32) valid one cycle after a read
// ---------------------------------------------------------------------------
module onchip_sram_port_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [13:0] m0_address,
   input  logic [3:0]  m0_byteenable,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,

   input  logic [13:0] m1_address,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,

   output logic [13:0] sram_address,
   output logic [3:0]  sram_byteenable,
   output logic [31:0] sram_writedata,
   output logic        sram_chipselect,
   output logic        sram_write,
   input  logic [31:0] sram_readdata
);

   typedef enum logic {
      MASTER0 = 1'b0,
      MASTER1 = 1'b1
   } master_e;

   localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

   master_e    last;
   logic [3:0] streak;
   logic       rd_pend;
   master_e    rd_owner;

   logic       req0;
   logic       req1;
   logic       grant_valid;
   master_e    grant;
   logic       grant_write;
   logic       grant_read;

   // Arbitration. Decided combinationally every cycle from the request lines
   // and registered state only, so waitrequest never depends on sram_readdata.
   // On a tie the last master keeps the port until its streak reaches
   // MAX_HOLD, then the port passes to the other master. Nothing is granted
   // while reset is high.
   always_comb begin
      req0        = m0_read | m0_write;
      req1        = m1_read | m1_write;
      grant_valid = 1'b0;
      grant       = MASTER0;
      if (!reset) begin
         if (req0 && req1) begin
            grant_valid = 1'b1;
            if (streak < HOLD_LIMIT)
               grant = last;
            else
               grant = (last == MASTER0) ? MASTER1 : MASTER0;
         end else if (req0) begin
            grant_valid = 1'b1;
            grant       = MASTER0;
         end else if (req1) begin
            grant_valid = 1'b1;
            grant       = MASTER1;
         end
      end
   end

   // Steer the granted master onto the SRAM port. A read asserted together
   // with a write counts as a write and never produces a response. With no
   // grant the m0 command fields are passed through as don't-cares. Both
   // masters always see sram_readdata; only readdatavalid is steered.
   always_comb begin
      grant_write = (grant == MASTER1) ? m1_write : m0_write;
      grant_read  = ((grant == MASTER1) ? m1_read : m0_read) & ~grant_write;

      sram_chipselect = grant_valid;
      sram_write      = grant_valid & grant_write;

      if (grant_valid && (grant == MASTER1)) begin
         sram_address    = m1_address;
         sram_byteenable = m1_byteenable;
         sram_writedata  = m1_writedata;
      end else begin
         sram_address    = m0_address;
         sram_byteenable = m0_byteenable;
         sram_writedata  = m0_writedata;
      end

      m0_waitrequest = ~(grant_valid && (grant == MASTER0));
      m1_waitrequest = ~(grant_valid && (grant == MASTER1));

      m0_readdata = sram_readdata;
      m1_readdata = sram_readdata;

      // A read accepted just before reset rises must not be reported.
      m0_readdatavalid = rd_pend && (rd_owner == MASTER0) && !reset;
      m1_readdatavalid = rd_pend && (rd_owner == MASTER1) && !reset;
   end

   // Arbitration history and read tracking. The streak counts consecutive
   // grants to the last master and saturates at MAX_HOLD; an idle cycle
   // clears it but keeps the last master, so the next tie goes back to it.
   // rd_pend marks that the SRAM output holds read data for rd_owner in the
   // following cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         last     <= MASTER0;
         streak   <= '0;
         rd_pend  <= 1'b0;
         rd_owner <= MASTER0;
      end else begin
         if (grant_valid) begin
            if (grant == last) begin
               if (streak < HOLD_LIMIT)
                  streak <= streak + 4'd1;
            end else begin
               last   <= grant;
               streak <= 4'd1;
            end
         end else begin
            streak <= '0;
         end

         rd_pend <= grant_valid & grant_read;
         if (grant_valid && grant_read)
            rd_owner <= grant;
      end
   end

endmodule

// File: doc/onchip_sram_port_arbiter.md
# onchip_sram_port_arbiter

Two-master arbiter that shares one port of the 16K x 32 on-chip SRAM (14-bit word address, 4 byte lanes, unregistered output, 1-cycle read latency) between two Avalon-MM requesters, e.g. the ECG sample capture DMA and the filter engine. Round-robin with a bounded grant hold lets a master stream short bursts without starving the other. The block sits between both masters and the SRAM port's chipselect/write/address/byteenable/writedata/readdata pins; the SRAM clock enable is tied high outside this block.

## Interface
- MAX_HOLD, 4, max consecutive granted transfers for one master while the other is waiting; legal 1..15 (1 = pure round-robin)
- clk  in  1  single clock, shared with the SRAM port
- reset  in  1  synchronous, active-high
- m0_address / m1_address  in  14  word address
- m0_byteenable / m1_byteenable  in  4  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  32  write data
- m0_waitrequest / m1_waitrequest  out  1  high = command not accepted this cycle
- m0_readdata / m1_readdata  out  32  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid
- sram_address  out  14, sram_byteenable  out  4, sram_writedata  out  32
- sram_chipselect  out  1, sram_write  out  1
- sram_readdata  in  32  SRAM q, valid the cycle after a read is issued

## Operation
- Request: req_i = mi_read | mi_write. mi_read & mi_write together: treated as a write, no readdatavalid.
- State: last (1 bit, last granted master), streak (4 bits, consecutive grants to last, saturating at MAX_HOLD), rd_pend (1 bit), rd_owner (1 bit).
- Grant g, combinational each cycle: no req -> none; one req -> that master; both -> last if streak < MAX_HOLD, else ~last.
- Granted master: waitrequest=0, its address/byteenable/writedata/write driven onto sram_*, sram_chipselect=1. Other master: waitrequest=1. No grant: sram_chipselect=0, sram_write=0, sram_address/byteenable/writedata = m0 values (don't-care).
- Waitrequest is asserted for a master that is not requesting (don't-care for it; bench does not check).
- Update on grant: g==last -> streak<=min(streak+1,MAX_HOLD); g!=last -> last<=g, streak<=1. No grant -> streak<=0, last held.
- Read issue: granted read (not write) sets rd_pend<=1, rd_owner<=g; else rd_pend<=0.
- Response: rd_pend -> m{rd_owner}_readdatavalid=1, m{rd_owner}_readdata=sram_readdata. readdata of both masters is always wired to sram_readdata; only readdatavalid is steered.
- Simultaneous read response and new grant are independent; back-to-back reads by either master sustain 1 transfer/cycle.
- Address/data are never modified; wrap-around is the SRAM's (14-bit, no bounds check).

## Timing
- Command acceptance: 0-cycle arbitration; accepted in the same cycle the request is presented if granted.
- Read latency: readdatavalid exactly 1 cycle after the accepting edge; one outstanding read at most per cycle, no reordering.
- Write: committed to SRAM at the accepting edge; no response.
- Reset (synchronous, sampled on clk): last=0, streak=0, rd_pend=0. While reset is high: both waitrequest=1, sram_chipselect=0, sram_write=0, both readdatavalid=0. First cycle after reset with both requesting -> m0 granted.
- Reset mid-read: a read accepted on the cycle before reset asserts produces no readdatavalid.
- Worst-case wait for a requesting master with other master continuously requesting: MAX_HOLD cycles.
- No combinational path from sram_readdata to waitrequest; waitrequest depends only on req inputs and registered state.

## Test plan
- Single master: m0 writes 0xDEADBEEF to addr 0x0010, byteenable 0xF, then reads 0x0010 -> waitrequest 0 both cycles, m0_readdatavalid=1 one cycle after read with 0xDEADBEEF; m1_readdatavalid stays 0.
- Contention, MAX_HOLD=4: m0 and m1 both request reads continuously from reset -> grant pattern m0 x4, m1 x4, m0 x4...; each readdatavalid lands on the correct master exactly 1 cycle after its acceptance.
- MAX_HOLD=1: both request continuously -> strict alternation m0,m1,m0,m1; idle cycle in between resets streak, and next tie goes to last.
- Byte lanes: m1 writes 0x11223344 byteenable 0x3 over prior 0xAAAAAAAA at 0x3FFF -> m0 read of 0x3FFF returns 0xAAAA3344.
- Read+write asserted together on m0 -> treated as write, no m0_readdatavalid.
- Reset mid-operation: assert reset the cycle after m1 read is accepted -> no readdatavalid, both waitrequest=1, sram_chipselect=0 during reset; after release, tie goes to m0.
